// File: rtl/draw_pkg.sv
// Constants and state type shared by the draw-region pair writer and reader.
package draw_pkg;

    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BASE_PAIR = 4096;
    localparam int unsigned END_PAIR  = 5120;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SEND_A,
        SEND_B,
        DONE
    } rd_state_t;

endpackage

// File: rtl/draw_pair_addr_gen.sv
// Pair index register with last-pair compare and even/odd word address formation.
module draw_pair_addr_gen
    import draw_pkg::*;
#(
    parameter int unsigned AW        = ADDR_W,
    parameter int unsigned BASE      = BASE_PAIR,
    parameter int unsigned END_INDEX = END_PAIR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic          inc_i,
    output logic          last_o,
    output logic [AW-1:0] addr_a_o,
    output logic [AW-1:0] addr_b_o
);

    localparam int unsigned PW = AW - 1;

    logic [PW-1:0] pair_d, pair_q;

    always_comb begin
        pair_d = pair_q;
        if (load_i) begin
            pair_d = PW'(BASE);
        end else if (inc_i) begin
            pair_d = pair_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pair_q <= PW'(BASE);
        end else begin
            pair_q <= pair_d;
        end
    end

    assign last_o   = (pair_q == PW'(END_INDEX - 1));
    assign addr_a_o = {pair_q, 1'b0};
    assign addr_b_o = {pair_q, 1'b1};

endmodule

// File: rtl/draw_pair_reader.sv
// Reads the draw region two words per access and streams them out even word first.
// Define READER_LOOP_EN to repeat passes back to back until reset.
module draw_pair_reader
    import draw_pkg::*;
#(
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] rdata_a,
    input  logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LatW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    rd_state_t         state_d, state_q;
    logic [LatW-1:0]   lat_cnt_d, lat_cnt_q;
    logic [DATA_W-1:0] hold_a_d, hold_a_q;
    logic [DATA_W-1:0] hold_b_d, hold_b_q;
    logic              pair_load, pair_inc, pair_last;

    draw_pair_addr_gen #(
        .AW        (ADDR_W),
        .BASE      (BASE_PAIR),
        .END_INDEX (END_PAIR)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .load_i   (pair_load),
        .inc_i    (pair_inc),
        .last_o   (pair_last),
        .addr_a_o (addr_a),
        .addr_b_o (addr_b)
    );

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        hold_a_d  = hold_a_q;
        hold_b_d  = hold_b_q;
        pair_load = 1'b0;
        pair_inc  = 1'b0;
        rd_en     = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pair_load = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                rd_en     = 1'b1;
                lat_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (lat_cnt_q == LatW'(RAM_LAT - 1)) begin
                    hold_a_d = rdata_a;
                    hold_b_d = rdata_b;
                    state_d  = SEND_A;
                end else begin
                    lat_cnt_d = lat_cnt_q + LatW'(1);
                end
            end
            SEND_A: begin
                out_valid = 1'b1;
                out_data  = hold_a_q;
                if (out_ready) begin
                    state_d = SEND_B;
                end
            end
            SEND_B: begin
                out_valid = 1'b1;
                out_data  = hold_b_q;
                out_last  = pair_last;
                if (out_ready) begin
                    if (pair_last) begin
`ifdef READER_LOOP_EN
                        // Wrap straight into the next pass; done marks the boundary.
                        done      = 1'b1;
                        pair_load = 1'b1;
                        state_d   = ISSUE;
`else
                        state_d   = DONE;
`endif
                    end else begin
                        pair_inc = 1'b1;
                        state_d  = ISSUE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            hold_a_q  <= hold_a_d;
            hold_b_q  <= hold_b_d;
        end
    end

endmodule

// File: tb/tb_draw_pair_reader.sv
// Directed bench for draw_pair_reader; the RAM model returns addr[7:0] as data.
module tb_draw_pair_reader;
    import draw_pkg::*;

`ifdef READER_LOOP_EN
    localparam int unsigned LAT = 3;
`else
    localparam int unsigned LAT = 1;
`endif
    localparam int FIRST_ADDR = 8192;
    localparam int LAST_ADDR  = 10239;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic              rd_en, out_valid, out_last, busy, done;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] rdata_a, rdata_b, out_data;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    draw_pair_reader #(
        .RAM_LAT (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_en     (rd_en),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // RAM with LAT-cycle read latency; 0xEE appears when no read was issued.
    logic [DATA_W-1:0] pipe_a [LAT];
    logic [DATA_W-1:0] pipe_b [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
        pipe_a[0] <= rd_en ? addr_a[7:0] : 8'hEE;
        pipe_b[0] <= rd_en ? addr_b[7:0] : 8'hEE;
    end
    assign rdata_a = pipe_a[LAT-1];
    assign rdata_b = pipe_b[LAT-1];

    // Stream monitor, sampled on the falling edge; cleared by reset.
    int          cyc = 0;
    int          mon_words, mon_bad, mon_last, mon_done, mon_rd;
    int          mon_word_addr, mon_rd_addr;
    int          first_rd_cyc, done_cyc, prev_done_cyc;
    logic        prev_stall, prev_last;
    logic [7:0]  prev_data;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            mon_words = 0; mon_bad = 0; mon_last = 0; mon_done = 0; mon_rd = 0;
            mon_word_addr = FIRST_ADDR; mon_rd_addr = FIRST_ADDR;
            first_rd_cyc = 0; done_cyc = 0; prev_done_cyc = 0; prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                mon_bad++;
            if (rd_en) begin
                if (mon_rd == 0) first_rd_cyc = cyc;
                if (addr_a !== 14'(mon_rd_addr) || addr_b !== 14'(mon_rd_addr + 1)) mon_bad++;
                mon_rd++;
                mon_rd_addr = (mon_rd_addr + 2 > LAST_ADDR) ? FIRST_ADDR : mon_rd_addr + 2;
            end
            if (done) begin
                prev_done_cyc = done_cyc;
                done_cyc = cyc;
                mon_done++;
            end
            if (out_valid && out_ready) begin
                if (out_data !== 8'(mon_word_addr)) mon_bad++;
                if (out_last !== (mon_word_addr == LAST_ADDR)) mon_bad++;
                if (out_last) mon_last++;
                mon_words++;
                mon_word_addr = (mon_word_addr == LAST_ADDR) ? FIRST_ADDR : mon_word_addr + 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int count, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step(1);
            if (mon_done >= count) ok = 1'b1;
        end
    endtask

    task automatic wait_word(input int addr, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step(1);
            if (out_valid && mon_word_addr == addr) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        step(3);
        n_assert++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_assert++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        n_assert++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_assert++; if (addr_a !== 14'd8192 || addr_b !== 14'd8193) begin
            n_fail++; $display("FAIL reset_addr: got %0d/%0d want 8192/8193", addr_a, addr_b); end
        reset = 1'b0;
        start = 1'b0;
        step(2);
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_during_reset: busy %b want 0", busy); end
    endtask

    task automatic check_pass(input string name);
        n_assert++; if (mon_words !== 2048) begin n_fail++; $display("FAIL %s_words: got %0d want 2048", name, mon_words); end
        n_assert++; if (mon_bad !== 0) begin n_fail++; $display("FAIL %s_stream: %0d bad events want 0", name, mon_bad); end
        n_assert++; if (mon_last !== 1) begin n_fail++; $display("FAIL %s_last: got %0d want 1", name, mon_last); end
        n_assert++; if (mon_done !== 1) begin n_fail++; $display("FAIL %s_done: got %0d want 1", name, mon_done); end
        n_assert++; if (mon_rd !== 1024) begin n_fail++; $display("FAIL %s_reads: got %0d want 1024", name, mon_rd); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: busy %b want 0", name, busy); end
    endtask

    task automatic test_full_pass();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        wait_done(1, 6000, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL full_timeout: done %0d want 1", mon_done); end
        n_assert++; if (done_cyc - first_rd_cyc !== 4096) begin
            n_fail++; $display("FAIL full_cycles: got %0d want 4096", done_cyc - first_rd_cyc); end
        step(20);
        check_pass("full");
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        wait_word(8200, 2000, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL bp_reach: word 8200 not reached"); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            n_assert++; if (out_valid !== 1'b1 || out_data !== 8'h08 || rd_en !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold: valid %b data %h rd_en %b want 1 08 0", out_valid, out_data, rd_en); end
        end
        out_ready = 1'b1;
        step(1);
        n_assert++; if (out_valid !== 1'b1 || out_data !== 8'h09) begin
            n_fail++; $display("FAIL bp_next: valid %b data %h want 1 09", out_valid, out_data); end
        wait_done(1, 6000, ok);
        step(5);
        check_pass("bp");
    endtask

    task automatic test_random_ready();
        bit ok;
        do_reset();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            step(1);
            if (mon_done >= 1) ok = 1'b1;
        end
        out_ready = 1'b1;
        n_assert++; if (!ok) begin n_fail++; $display("FAIL rand_timeout: done %0d want 1", mon_done); end
        step(20);
        check_pass("rand");
    endtask

    task automatic test_reset_mid_pass();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        wait_word(9001, 4000, ok);
        n_assert++; if (!ok || out_last !== 1'b0) begin n_fail++; $display("FAIL mid_reach: ok %b", ok); end
        reset = 1'b1;
        step(1);
        n_assert++; if ({rd_en, out_valid, out_last, busy, done} !== 5'b0 || out_data !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset_outs: got %b/%h want 00000/00",
                {rd_en, out_valid, out_last, busy, done}, out_data); end
        n_assert++; if (addr_a !== 14'd8192) begin n_fail++; $display("FAIL mid_reset_addr: got %0d want 8192", addr_a); end
        reset = 1'b0;
        step(1);
        pulse_start();
        n_assert++; if (rd_en !== 1'b1 || addr_a !== 14'd8192) begin
            n_fail++; $display("FAIL mid_restart: rd_en %b addr %0d want 1 8192", rd_en, addr_a); end
        wait_done(1, 6000, ok);
        step(5);
        check_pass("mid");
    endtask

    task automatic test_start_while_busy();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        wait_word(8400, 2000, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL busy_reach: word 8400 not reached"); end
        pulse_start();
        wait_done(1, 6000, ok);
        step(30);
        check_pass("busy_start");
    endtask

    task automatic test_loop();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        pulse_start();
        wait_done(1, 8000, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL loop_timeout1: done %0d want 1", mon_done); end
        n_assert++; if (done_cyc - first_rd_cyc !== 6143) begin
            n_fail++; $display("FAIL loop_cycles: got %0d want 6143", done_cyc - first_rd_cyc); end
        n_assert++; if (rd_en !== 1'b1 || addr_a !== 14'd8192 || busy !== 1'b1) begin
            n_fail++; $display("FAIL loop_wrap: rd_en %b addr %0d busy %b want 1 8192 1", rd_en, addr_a, busy); end
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_assert++; if (out_valid !== 1'b0 || rd_en !== 1'b0) begin
                n_fail++; $display("FAIL loop_wait: valid %b rd_en %b want 0 0", out_valid, rd_en); end
        end
        step(1);
        n_assert++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            n_fail++; $display("FAIL loop_first: valid %b data %h want 1 00", out_valid, out_data); end
        wait_done(2, 8000, ok);
        n_assert++; if (!ok || done_cyc - prev_done_cyc !== 6144) begin
            n_fail++; $display("FAIL loop_period: got %0d want 6144", done_cyc - prev_done_cyc); end
        n_assert++; if (mon_words !== 4096 || mon_last !== 2 || mon_bad !== 0) begin
            n_fail++; $display("FAIL loop_stream: words %0d last %0d bad %0d want 4096 2 0",
                mon_words, mon_last, mon_bad); end
        n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy: got %b want 1", busy); end
        do_reset();
    endtask

    initial begin
        test_reset();
`ifdef READER_LOOP_EN
        test_loop();
`else
        test_full_pass();
        test_backpressure();
        test_random_ready();
        test_reset_mid_pass();
        test_start_while_busy();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/draw_pair_reader.md
Name: draw_pair_reader

Overview:
- Read-side counterpart of the draw-region pair writer.
- Walks the same dual-port RAM region two words per access, even address on port A and odd address on port B.
- Captures both read words and streams them out one word at a time over a valid/ready handshake, even word first.
- Sits between the frame RAM read ports and the downstream pixel consumer.

Parameters:
- ADDR_W, 14, RAM word-address width; pair index is ADDR_W-1 bits.
- DATA_W, 8, RAM word width.
- BASE_PAIR, 4096, first pair index; word addresses 8192/8193.
- END_PAIR, 5120, exclusive end pair index; last words 10238/10239; 1024 pairs, 2048 words.
- RAM_LAT, 1, RAM read latency in cycles (>=1).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins one region pass when idle
- rd_en  out  1  read strobe to both RAM ports
- addr_a  out  ADDR_W  port A address = {pair,1'b0}
- addr_b  out  ADDR_W  port B address = {pair,1'b1}
- rdata_a  in  DATA_W  port A read data
- rdata_b  in  DATA_W  port B read data
- out_data  out  DATA_W  streamed word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when valid&&ready
- out_last  out  1  high with the final word (address END_PAIR*2-1)
- busy  out  1  high from start acceptance until DONE exits
- done  out  1  one-cycle pulse at pass completion

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-high, and has priority over all other activity.
- Reset values: state=IDLE, pair=BASE_PAIR, rd_en=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0, hold regs=0.
- addr_a/addr_b are driven combinationally from pair at all times.
- IDLE: busy=0. start=1 -> ISSUE, pair<=BASE_PAIR. start while busy is ignored and is not queued.
- ISSUE: rd_en=1 for exactly one cycle, then -> WAIT with lat_cnt=0.
- WAIT: lasts RAM_LAT cycles. In the final WAIT cycle, rdata_a and rdata_b are registered into hold_a/hold_b -> SEND_A.
- SEND_A: out_valid=1, out_data=hold_a, out_last=0. On out_ready -> SEND_B.
- SEND_B: out_valid=1, out_data=hold_b, out_last=(pair==END_PAIR-1). On out_ready: if last -> DONE, else pair<=pair+1 -> ISSUE.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- Handshake: while out_valid&&!out_ready, out_data and out_last must hold stable. out_valid never drops before acceptance. No combinational path from out_ready to out_valid.
- Throughput with RAM_LAT=1 and ready held high: 4 cycles per pair (ISSUE, WAIT, SEND_A, SEND_B). A full pass is 4096 cycles from ISSUE entry to DONE entry.
- Width: pair counter is ADDR_W-1 bits. Increment never wraps within a pass because END_PAIR <= 2^(ADDR_W-1).
- Reset mid-pass: abandons the pass, returns to reset values, and any in-flight RAM data is discarded.
- start coincident with reset: reset wins.

Optional Feature:
- READER_LOOP_EN defined: at the end of a pass, done pulses in the same cycle as the transition to ISSUE with pair<=BASE_PAIR. Passes repeat until reset, busy stays 1, and no DONE state dwell occurs.
- Undefined: single pass with DONE, then IDLE, as described above.

Decomposition:
- Package draw_pkg holds: ADDR_W, DATA_W, BASE_PAIR, END_PAIR constants shared with the writer, and the state enum typedef rd_state_t {IDLE, ISSUE, WAIT, SEND_A, SEND_B, DONE}.
- One natural sub-module: draw_pair_addr_gen, containing the pair register, the increment/last compare, and the {pair,0}/{pair,1} address formation.

Test Plan:
- Reset then start, ready=1, RAM model returns data=addr[7:0]: stream is 0x00,0x01,...,0xFF repeating, 2048 words total. Address sequence runs 8192..10239. out_last is asserted only on the word from address 10239. done pulses once, 4096 cycles after ISSUE entry.
- Hold out_ready=0 for 5 cycles during SEND_A of pair 4100: out_data stays at word 8200 throughout and no rd_en is issued. After ready rises, the next word is 8201.
- Random out_ready (50%) over a full pass: no words lost or duplicated, order is strictly ascending, exactly one done pulse.
- Assert reset at pair 4500, during SEND_B: on the next cycle all outputs match reset values. A new start restarts from address 8192.
- Pulse start again while busy at pair 4200: no effect, and the stream continues uninterrupted.
- With READER_LOOP_EN and RAM_LAT=3: after word 10239 is accepted, done pulses and the next rd_en carries address 8192. WAIT spans 3 cycles, and the second pass matches the first.
